// File: rtl/d_cache_mem_port_pkg.sv
// Shared codes for the data-cache memory port: memory signal/status encodings,
// port FSM state encoding and the default burst length.
package d_cache_mem_port_pkg;

  localparam logic [1:0] MEM_NOP          = 2'b00;
  localparam logic [1:0] MEM_WRITE        = 2'b01;
  localparam logic [1:0] MEM_READ_BURST   = 2'b10;

  localparam logic [1:0] MEM_FINISHED     = 2'b00;
  localparam logic [1:0] MEM_DATA_WORKING = 2'b01;

  localparam logic [2:0] DCP_IDLE      = 3'd0;
  localparam logic [2:0] DCP_WRITE     = 3'd1;
  localparam logic [2:0] DCP_READ      = 3'd2;
  localparam logic [2:0] DCP_READ_TAIL = 3'd3;
  localparam logic [2:0] DCP_DONE      = 3'd4;

  localparam int DCP_BURST_WORDS_DEFAULT = 3;

endpackage

// File: rtl/d_cache_mem_port.sv
// Memory-side transfer engine of the data cache: turns one fill or write-back
// request into a MEM_READ_BURST / MEM_WRITE word sequence and reports completion.
module d_cache_mem_port
  import d_cache_mem_port_pkg::*;
#(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int BURST_WORDS      = DCP_BURST_WORDS_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_write,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  input  logic [ENTRY_INDEX_SIZE:0]             req_len,
  input  logic [LEN*(2**ENTRY_INDEX_SIZE)-1:0]  req_line,
  output logic                                  resp_valid,
  output logic                                  resp_err,
  output logic [LEN*(2**ENTRY_INDEX_SIZE)-1:0]  resp_line,
  output logic                                  protocol_err,
  output logic [1:0]                            d_cache_mem_vis_signal,
  output logic [ADDR_WIDTH-1:0]                 d_cache_mem_vis_addr,
  output logic [ENTRY_INDEX_SIZE:0]             length,
  output logic [LEN-1:0]                        writen_data,
  input  logic [LEN-1:0]                        mem_data,
  input  logic [1:0]                            mem_status
);

  localparam int LINE_WORDS = 2**ENTRY_INDEX_SIZE;
  localparam int LW         = LEN*LINE_WORDS;
  localparam int KW         = ENTRY_INDEX_SIZE+1;

  logic [2:0]                  state_reg, state_next;
  logic [KW-1:0]               k_reg;
  logic [ADDR_WIDTH-1:0]       addr_reg;
  logic [KW-1:0]               len_reg;
  logic [LW-1:0]               wline_reg;
  logic [LW-1:0]               fill_reg;
  logic                        err_reg;
  logic                        perr_reg;

  logic [LEN-1:0]              wword [LINE_WORDS];
  logic                        accept;
  logic                        len_ok;
  logic                        reject;
  logic [ADDR_WIDTH-1:0]       word_addr;
  logic [ENTRY_INDEX_SIZE-1:0] cap_idx;
  logic [ENTRY_INDEX_SIZE-1:0] tail_idx;

  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_wword
      assign wword[gi] = wline_reg[gi*LEN +: LEN];
    end
  endgenerate

  assign accept    = req_valid && (state_reg == DCP_IDLE);
  assign len_ok    = (req_len >= KW'(2)) && (req_len <= KW'(LINE_WORDS));
  assign reject    = req_write && !len_ok;
  assign word_addr = addr_reg + ADDR_WIDTH'({k_reg, 2'b00});
  // Read data lags the address by one cycle, so capture lands one word behind k.
  assign cap_idx   = ENTRY_INDEX_SIZE'(k_reg - KW'(1));
  assign tail_idx  = ENTRY_INDEX_SIZE'(BURST_WORDS-1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DCP_IDLE: begin
        if (accept) begin
          if (reject)         state_next = DCP_DONE;
          else if (req_write) state_next = DCP_WRITE;
          else                state_next = DCP_READ;
        end
      end
      DCP_WRITE:     if (k_reg == len_reg - KW'(1)) state_next = DCP_DONE;
      DCP_READ:      if (k_reg == KW'(BURST_WORDS-1)) state_next = DCP_READ_TAIL;
      DCP_READ_TAIL: state_next = DCP_DONE;
      DCP_DONE:      state_next = DCP_IDLE;
      default:       state_next = DCP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= DCP_IDLE;
      k_reg     <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      wline_reg <= '0;
      fill_reg  <= '0;
      err_reg   <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        DCP_IDLE: begin
          if (accept) begin
            k_reg     <= '0;
            addr_reg  <= req_addr & ~ADDR_WIDTH'(3);
            len_reg   <= req_len;
            wline_reg <= req_line;
            err_reg   <= reject;
            if (!req_write) fill_reg <= '0;
          end
        end
        DCP_WRITE: k_reg <= k_reg + KW'(1);
        DCP_READ: begin
          k_reg <= k_reg + KW'(1);
          if (k_reg != '0) fill_reg[cap_idx*LEN +: LEN] <= mem_data;
        end
        DCP_READ_TAIL: fill_reg[tail_idx*LEN +: LEN] <= mem_data;
        DCP_DONE: begin
          if (!err_reg && (mem_status != MEM_FINISHED)) perr_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    d_cache_mem_vis_signal = MEM_NOP;
    d_cache_mem_vis_addr   = '0;
    length                 = '0;
    writen_data            = '0;
    if (state_reg == DCP_WRITE) begin
      d_cache_mem_vis_signal = MEM_WRITE;
      d_cache_mem_vis_addr   = word_addr;
      length                 = len_reg;
      writen_data            = wword[k_reg[ENTRY_INDEX_SIZE-1:0]];
    end else if (state_reg == DCP_READ) begin
      d_cache_mem_vis_signal = MEM_READ_BURST;
      d_cache_mem_vis_addr   = word_addr;
    end
  end

  assign req_ready    = (state_reg == DCP_IDLE);
  assign resp_valid   = (state_reg == DCP_DONE);
  assign resp_err     = resp_valid && err_reg;
  assign resp_line    = fill_reg;
  assign protocol_err = perr_reg;

endmodule

// File: tb/tb_d_cache_mem_port.sv
// Directed bench for d_cache_mem_port with a small word memory model on the
// data-cache channel; prints one line per request.
module tb_d_cache_mem_port;
  import d_cache_mem_port_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [16:0]  req_addr = '0;
  logic [3:0]   req_len = '0;
  logic [255:0] req_line = '0;
  logic         resp_valid;
  logic         resp_err;
  logic [255:0] resp_line;
  logic         protocol_err;
  logic [1:0]   vis_signal;
  logic [16:0]  vis_addr;
  logic [3:0]   length;
  logic [31:0]  writen_data;
  logic [31:0]  mem_data;
  logic [1:0]   mem_status;

  always #5 clk = ~clk;

  d_cache_mem_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_line(req_line),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_line(resp_line),
    .protocol_err(protocol_err),
    .d_cache_mem_vis_signal(vis_signal), .d_cache_mem_vis_addr(vis_addr),
    .length(length), .writen_data(writen_data),
    .mem_data(mem_data), .mem_status(mem_status)
  );

  // memory model: registered read data, word writes, optional forced status
  logic [31:0] mem [0:32767];
  logic        pl_en = 1'b0;
  logic [16:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic        force_working = 1'b0;

  assign mem_status = force_working ? MEM_DATA_WORKING : MEM_FINISHED;

  always @(posedge clk) begin
    if (rst) mem_data <= '0;
    else begin
      if (pl_en) mem[pl_addr[16:2]] <= pl_data;
      if (vis_signal == MEM_WRITE) mem[vis_addr[16:2]] <= writen_data;
      if (vis_signal == MEM_READ_BURST) mem_data <= mem[vis_addr[16:2]];
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [16:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  logic [16:0] sig_addr [0:15];
  logic [1:0]  sig_kind [0:15];
  logic [3:0]  sig_len  [0:15];
  int          nsig;
  int          lat;
  logic        err_seen;
  logic [255:0] line_seen;

  task automatic issue(input logic w, input logic [16:0] a, input logic [3:0] l,
                       input logic [255:0] line);
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_line = line;
    tick();
    req_valid = 1'b0;
    nsig = 0; lat = 0; err_seen = 1'b0; line_seen = '0;
    for (int c = 1; c <= 20; c++) begin
      if (vis_signal != MEM_NOP && nsig < 16) begin
        sig_addr[nsig] = vis_addr;
        sig_kind[nsig] = vis_signal;
        sig_len[nsig]  = length;
        nsig++;
      end
      if (resp_valid) begin
        lat = c; err_seen = resp_err; line_seen = resp_line;
        break;
      end
      tick();
    end
    $display("req write=%0d addr=%05h len=%0d -> latency=%0d err=%0d mem_cycles=%0d line=%0h",
             w, a, l, lat, err_seen, nsig, line_seen);
    tick();
  endtask

  int rv_cnt;

  initial begin
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_protocol_err", protocol_err, 0);
    check("rst_signal", vis_signal, MEM_NOP);
    check("rst_addr", vis_addr, 0);
    check("rst_length", length, 0);
    check("rst_wdata", writen_data, 0);
    check("rst_resp_line", resp_line, 0);

    preload(17'h00100, 32'h11111111);
    preload(17'h00104, 32'h22222222);
    preload(17'h00108, 32'h33333333);
    preload(17'h1FFFC, 32'hDEAD0001);
    preload(17'h00000, 32'hDEAD0002);
    preload(17'h00004, 32'hDEAD0003);

    // fill at 0x100
    issue(1'b0, 17'h00100, 4'd0, '0);
    check("fill_lat", lat, 5);
    check("fill_nsig", nsig, 3);
    check("fill_addr0", sig_addr[0], 17'h00100);
    check("fill_addr1", sig_addr[1], 17'h00104);
    check("fill_addr2", sig_addr[2], 17'h00108);
    check("fill_kind", {sig_kind[0], sig_kind[1], sig_kind[2]},
          {MEM_READ_BURST, MEM_READ_BURST, MEM_READ_BURST});
    check("fill_err", err_seen, 0);
    check("fill_line", line_seen, 256'h33333333_22222222_11111111);
    check("fill_ready_after", req_ready, 1);

    // write-back L=4 at 0x200
    issue(1'b1, 17'h00200, 4'd4, 256'hA3_000000A2_000000A1_000000A0);
    check("wr_lat", lat, 5);
    check("wr_nsig", nsig, 4);
    check("wr_kind", {sig_kind[0], sig_kind[3]}, {MEM_WRITE, MEM_WRITE});
    check("wr_addr3", sig_addr[3], 17'h0020C);
    check("wr_length", {sig_len[0], sig_len[3]}, {4'd4, 4'd4});
    check("wr_mem0", mem[17'h00200 >> 2], 32'hA0);
    check("wr_mem1", mem[17'h00204 >> 2], 32'hA1);
    check("wr_mem2", mem[17'h00208 >> 2], 32'hA2);
    check("wr_mem3", mem[17'h0020C >> 2], 32'hA3);
    check("wr_err", err_seen, 0);
    check("wr_perr", protocol_err, 0);
    check("wr_keeps_fill_line", resp_line, 256'h33333333_22222222_11111111);

    // rejected lengths; forced status must not count against a rejected request
    force_working = 1'b1;
    issue(1'b1, 17'h00300, 4'd1, '1);
    check("rej1_lat", lat, 1);
    check("rej1_err", err_seen, 1);
    check("rej1_nsig", nsig, 0);
    issue(1'b1, 17'h00300, 4'd9, '1);
    force_working = 1'b0;
    check("rej9_lat", lat, 1);
    check("rej9_err", err_seen, 1);
    check("rej9_nsig", nsig, 0);
    check("rej_perr", protocol_err, 0);

    // upper boundary L=8 accepted
    issue(1'b1, 17'h00400, 4'd8, {8{32'h5A5A0000}});
    check("wr8_lat", lat, 9);
    check("wr8_nsig", nsig, 8);
    check("wr8_addr7", sig_addr[7], 17'h0041C);

    // low address bits ignored
    issue(1'b0, 17'h00103, 4'd0, '0);
    check("low_addr0", sig_addr[0], 17'h00100);
    check("low_line", line_seen, 256'h33333333_22222222_11111111);

    // wrap at top of address space
    issue(1'b0, 17'h1FFFC, 4'd0, '0);
    check("wrap_addr0", sig_addr[0], 17'h1FFFC);
    check("wrap_addr1", sig_addr[1], 17'h00000);
    check("wrap_addr2", sig_addr[2], 17'h00004);
    check("wrap_line", line_seen, 256'hDEAD0003_DEAD0002_DEAD0001);

    // reset during the second WRITE cycle
    req_valid = 1'b1; req_write = 1'b1; req_addr = 17'h00500; req_len = 4'd4;
    req_line = 256'h4_00000003_00000002_00000001;
    tick();
    req_valid = 1'b0;
    check("abort_first_write", vis_signal, MEM_WRITE);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_signal_nop", vis_signal, MEM_NOP);
    check("abort_ready", req_ready, 1);
    rv_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) rv_cnt++;
      tick();
    end
    check("abort_no_resp", rv_cnt, 0);
    $display("req write=1 addr=00500 len=4 -> aborted by reset, resp pulses=%0d", rv_cnt);

    // memory reporting busy at completion
    force_working = 1'b1;
    issue(1'b1, 17'h00600, 4'd2, 256'hBB_000000AA);
    force_working = 1'b0;
    check("perr_set", protocol_err, 1);
    issue(1'b0, 17'h00100, 4'd0, '0);
    check("perr_sticky", protocol_err, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("perr_cleared", protocol_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
